// File: rtl/tia_biphase_decoder_pkg.sv
// Shared definitions for the TIA biphase receive decoder.
//   biphase_state_e : decoder tracking states (encodings fixed for
//                     compatibility with the transmit-side clock block)
//   NOMINAL_PERIOD  : nominal hphi1/hphi2 period in master-clock cycles
package tia_biphase_decoder_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        WAIT_P2 = 2'd1,
        WAIT_P1 = 2'd2
    } biphase_state_e;

    localparam int unsigned NOMINAL_PERIOD = 4;

endpackage

// File: rtl/tia_biphase_decoder_if.sv
// Bus bundle between a biphase source/bench and the biphase decoder.
//   hphi1, hphi2   : two-phase clock pair, synchronous to the master clock
//   clr_err        : synchronous clear of the sticky error flags
//   p1_stb, p2_stb : single-cycle rising-edge strobes
//   locked         : phase stream trusted
//   cycle_count    : completed phi1->phi2 pairs (modulo 2^CW)
//   err_*          : sticky fault flags
// Modports: master drives the phases, slave is the decoder.
interface tia_biphase_decoder_if #(
    parameter int CW = 8
);
    logic          hphi1;
    logic          hphi2;
    logic          clr_err;
    logic          p1_stb;
    logic          p2_stb;
    logic          locked;
    logic [CW-1:0] cycle_count;
    logic          err_overlap;
    logic          err_order;
    logic          err_timeout;

    modport master (
        output hphi1, hphi2, clr_err,
        input  p1_stb, p2_stb, locked, cycle_count,
               err_overlap, err_order, err_timeout
    );

    modport slave (
        input  hphi1, hphi2, clr_err,
        output p1_stb, p2_stb, locked, cycle_count,
               err_overlap, err_order, err_timeout
    );
endinterface

// File: rtl/tia_biphase_edge.sv
// Rising-edge detector for one biphase phase line.
//   clk, rsynl : master clock, async active-low reset
//   din        : phase input sampled on clk
//   rise       : combinational rise (din high, previous sample low)
//   stb        : registered one-clock strobe of rise
module tia_biphase_edge (
    input  logic clk,
    input  logic rsynl,
    input  logic din,
    output logic rise,
    output logic stb
);
    logic prev_r;
    logic stb_r;

    assign rise = din & ~prev_r;
    assign stb  = stb_r;

    // Previous-sample flop and registered strobe.
    always_ff @(posedge clk or negedge rsynl) begin
        if (!rsynl) begin
            prev_r <= 1'b0;
            stb_r  <= 1'b0;
        end else begin
            prev_r <= din;
            stb_r  <= rise;
        end
    end
endmodule

// File: rtl/tia_biphase_decoder.sv
// Decodes the hphi1/hphi2 two-phase clock into phase strobes, a count of
// valid phi1->phi2 pairs and a lock indication, with sticky overlap,
// ordering and timeout fault flags.
//   clk   : master clock
//   rsynl : asynchronous active-low reset
//   bus   : decoder side of tia_biphase_decoder_if (phases in, status out)
module tia_biphase_decoder
    import tia_biphase_decoder_pkg::*;
#(
    parameter int CW          = 8,
    parameter int TW          = 4,
    parameter int TIMEOUT     = 8,
    parameter int LOCK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rsynl,
    tia_biphase_decoder_if.slave  bus
);
    localparam int GW = $clog2(LOCK_CYCLES + 1);
    // Timeout fires on the edge where the timer would step onto TIMEOUT.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LOCK_VAL = GW'(LOCK_CYCLES);

    logic rise1_s, rise2_s, overlap_s;

    biphase_state_e state_r, state_s;
    logic [TW-1:0]  timer_r, timer_s;
    logic [GW-1:0]  good_r, good_s;
    logic [CW-1:0]  count_r, count_s;
    logic           ovl_s, ord_s, tmo_s;
    logic           err_overlap_r, err_order_r, err_timeout_r, locked_r;

    tia_biphase_edge u_edge_p1 (
        .clk   (clk),
        .rsynl (rsynl),
        .din   (bus.hphi1),
        .rise  (rise1_s),
        .stb   (bus.p1_stb)
    );

    tia_biphase_edge u_edge_p2 (
        .clk   (clk),
        .rsynl (rsynl),
        .din   (bus.hphi2),
        .rise  (rise2_s),
        .stb   (bus.p2_stb)
    );

    assign overlap_s = bus.hphi1 & bus.hphi2;

    // Next-state, timer, pair counting and fault detection.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        good_s  = good_r;
        count_s = count_r;
        ovl_s   = 1'b0;
        ord_s   = 1'b0;
        tmo_s   = 1'b0;
        if (overlap_s) begin
            // Overlap pre-empts any rise seen on the same edge.
            ovl_s   = 1'b1;
            good_s  = '0;
            state_s = HUNT;
            timer_s = '0;
        end else begin
            case (state_r)
                HUNT: begin
                    timer_s = '0;
                    if (rise1_s) begin
                        state_s = WAIT_P2;
                    end else begin
                        state_s = HUNT;
                    end
                end
                WAIT_P2: begin
                    if (rise2_s) begin
                        count_s = count_r + CW'(1);
                        if (good_r != LOCK_VAL) begin
                            good_s = good_r + GW'(1);
                        end else begin
                            good_s = good_r;
                        end
                        state_s = WAIT_P1;
                        timer_s = '0;
                    end else if (rise1_s) begin
                        // A fresh phi1 restarts the pair.
                        ord_s   = 1'b1;
                        good_s  = '0;
                        timer_s = '0;
                    end else if (timer_r == TMO_LAST) begin
                        tmo_s   = 1'b1;
                        good_s  = '0;
                        state_s = HUNT;
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + TW'(1);
                    end
                end
                WAIT_P1: begin
                    if (rise1_s) begin
                        state_s = WAIT_P2;
                        timer_s = '0;
                    end else if (rise2_s) begin
                        ord_s   = 1'b1;
                        good_s  = '0;
                        state_s = HUNT;
                        timer_s = '0;
                    end else if (timer_r == TMO_LAST) begin
                        tmo_s   = 1'b1;
                        good_s  = '0;
                        state_s = HUNT;
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + TW'(1);
                    end
                end
                default: begin
                    state_s = HUNT;
                    timer_s = '0;
                    good_s  = '0;
                end
            endcase
        end
    end

    // State, counters, sticky flags and lock register.
    always_ff @(posedge clk or negedge rsynl) begin
        if (!rsynl) begin
            state_r       <= HUNT;
            timer_r       <= '0;
            good_r        <= '0;
            count_r       <= '0;
            err_overlap_r <= 1'b0;
            err_order_r   <= 1'b0;
            err_timeout_r <= 1'b0;
            locked_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            good_r        <= good_s;
            count_r       <= count_s;
            // A fault on the clearing edge keeps its flag set.
            err_overlap_r <= ovl_s | (err_overlap_r & ~bus.clr_err);
            err_order_r   <= ord_s | (err_order_r   & ~bus.clr_err);
            err_timeout_r <= tmo_s | (err_timeout_r & ~bus.clr_err);
            // Lock follows the registered pair count, so it trails a fault by a clock.
            locked_r      <= (good_r == LOCK_VAL);
        end
    end

    assign bus.locked      = locked_r;
    assign bus.cycle_count = count_r;
    assign bus.err_overlap = err_overlap_r;
    assign bus.err_order   = err_order_r;
    assign bus.err_timeout = err_timeout_r;
endmodule

// File: tb/tb_tia_biphase_decoder.sv
// Directed self-checking bench for tia_biphase_decoder: reset, nominal
// lock, overlap, ordering, timeout, clear priority, mid-run reset, wrap.
module tb_tia_biphase_decoder;
    import tia_biphase_decoder_pkg::*;

    logic clk;
    logic rsynl;
    int   n_cmp;
    int   n_mis;

    tia_biphase_decoder_if #(.CW(8)) dut_bus ();

    tia_biphase_decoder #(
        .CW(8), .TW(4), .TIMEOUT(8), .LOCK_CYCLES(2)
    ) dut (
        .clk   (clk),
        .rsynl (rsynl),
        .bus   (dut_bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one clock of inputs; return #1 after the sampling edge.
    task automatic tick(input logic h1, input logic h2, input logic clr);
        @(negedge clk);
        dut_bus.hphi1   = h1;
        dut_bus.hphi2   = h2;
        dut_bus.clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    // One nominal period: hphi1 high in slot 0, hphi2 high in slot 2.
    task automatic period();
        for (int k = 0; k < int'(NOMINAL_PERIOD); k++) begin
            tick(k == 0, k == 2, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_p1"},  32'(dut_bus.p1_stb),      32'd0);
        check_val({tag, "_p2"},  32'(dut_bus.p2_stb),      32'd0);
        check_val({tag, "_lk"},  32'(dut_bus.locked),      32'd0);
        check_val({tag, "_cnt"}, 32'(dut_bus.cycle_count), 32'd0);
        check_val({tag, "_ovl"}, 32'(dut_bus.err_overlap), 32'd0);
        check_val({tag, "_ord"}, 32'(dut_bus.err_order),   32'd0);
        check_val({tag, "_tmo"}, 32'(dut_bus.err_timeout), 32'd0);
    endtask

    initial begin
        clk             = 1'b0;
        rsynl           = 1'b0;
        n_cmp           = 0;
        n_mis           = 0;
        dut_bus.hphi1   = 1'b0;
        dut_bus.hphi2   = 1'b0;
        dut_bus.clr_err = 1'b0;

        // Reset held with toggling inputs.
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        check_zero("rst_hold");
        @(negedge clk);
        rsynl = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        check_zero("rst_idle");

        // Nominal stream.
        tick(1'b1, 1'b0, 1'b0);
        check_val("nom_p1_stb", 32'(dut_bus.p1_stb), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        check_val("nom_p1_single", 32'(dut_bus.p1_stb), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        check_val("nom_p2_stb", 32'(dut_bus.p2_stb), 32'd1);
        check_val("nom_cnt1", 32'(dut_bus.cycle_count), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        check_val("nom_p2_single", 32'(dut_bus.p2_stb), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check_val("nom_lock_lag", 32'(dut_bus.locked), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check_val("nom_locked", 32'(dut_bus.locked), 32'd1);
        period();
        period();
        check_val("nom_cnt4", 32'(dut_bus.cycle_count), 32'd4);
        check_val("nom_noerr", {29'd0, dut_bus.err_overlap, dut_bus.err_order, dut_bus.err_timeout}, 32'd0);

        // Overlap while locked.
        tick(1'b1, 1'b1, 1'b0);
        check_val("ovl_flag", 32'(dut_bus.err_overlap), 32'd1);
        check_val("ovl_cnt_hold", 32'(dut_bus.cycle_count), 32'd4);
        tick(1'b0, 1'b0, 1'b0);
        check_val("ovl_unlock", 32'(dut_bus.locked), 32'd0);
        period();
        period();
        check_val("ovl_relock", 32'(dut_bus.locked), 32'd1);
        check_val("ovl_cnt6", 32'(dut_bus.cycle_count), 32'd6);
        tick(1'b0, 1'b0, 1'b1);
        check_val("clr_ovl", 32'(dut_bus.err_overlap), 32'd0);

        // Order: two phi1 rises without phi2.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check_val("ord_p1p1", 32'(dut_bus.err_order), 32'd1);
        check_val("ord_cnt_hold", 32'(dut_bus.cycle_count), 32'd6);
        tick(1'b0, 1'b0, 1'b0);
        check_val("ord_unlock", 32'(dut_bus.locked), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        check_val("ord_cnt7", 32'(dut_bus.cycle_count), 32'd7);
        tick(1'b0, 1'b0, 1'b1);
        check_val("clr_ord", 32'(dut_bus.err_order), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        check_val("ord_p2p2", 32'(dut_bus.err_order), 32'd1);
        check_val("ord_p2p2_cnt", 32'(dut_bus.cycle_count), 32'd7);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        check_val("hunt_p2_ignored", 32'(dut_bus.err_order), 32'd0);
        check_val("hunt_p2_nocnt", 32'(dut_bus.cycle_count), 32'd7);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
        check_val("hunt_no_tmo", 32'(dut_bus.err_timeout), 32'd0);

        // Timeout: accepted phi1 then silence.
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0);
        check_val("tmo_edge7", 32'(dut_bus.err_timeout), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check_val("tmo_edge8", 32'(dut_bus.err_timeout), 32'd1);
        tick(1'b0, 1'b1, 1'b0);
        check_val("tmo_hunt_ord", 32'(dut_bus.err_order), 32'd0);
        check_val("tmo_hunt_cnt", 32'(dut_bus.cycle_count), 32'd7);
        tick(1'b0, 1'b0, 1'b1);
        check_val("clr_tmo", 32'(dut_bus.err_timeout), 32'd0);

        // Clear on the same edge as a new overlap.
        tick(1'b1, 1'b1, 1'b1);
        check_val("clr_vs_ovl", 32'(dut_bus.err_overlap), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        period();
        check_val("pre_rst_cnt", 32'(dut_bus.cycle_count), 32'd8);

        // Asynchronous reset mid-pattern.
        tick(1'b1, 1'b0, 1'b0);
        #2;
        rsynl = 1'b0;
        #1;
        check_zero("rst_async");
        dut_bus.hphi1 = 1'b0;
        @(negedge clk);
        rsynl = 1'b1;
        period();
        check_val("rst_restart_cnt", 32'(dut_bus.cycle_count), 32'd1);

        // Count wraps modulo 256.
        for (int i = 0; i < 255; i++) period();
        check_val("wrap_cnt", 32'(dut_bus.cycle_count), 32'd0);
        check_val("wrap_locked", 32'(dut_bus.locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
